i2c_seg_target_rx: RTL and testbench

I2C target (slave) receiver that sits directly upstream of the 7-segment display controller. It samples the external SCL/SDA pins on the system clock and decodes START/STOP. It matches a 7-bit address, acknowledges write transfers, and hands each received data byte to the display stage as a one-cycle strobe with a per-transaction byte index. The block is write-only: read requests are not acknowledged.

---
 rtl/i2c_seg_pkg.sv | 22 ++
 rtl/i2c_line_sync.sv | 38 +++
 rtl/i2c_seg_target_rx.sv | 179 +++++++++++++++++
 tb/tb_i2c_seg_target_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : i2c_seg_pkg
// Brief    : Shared types and constants for the I2C 7-segment receive path.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_seg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2A;
    localparam logic [2:0] BYTE_IDX_MAX     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_line_sync
// Brief    : Two-flop synchronizer plus history flop with edge outputs.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign level = r_sync2;
    assign rise  = r_sync2 & ~r_hist;
    assign fall  = ~r_sync2 & r_hist;

endmodule
`default_nettype wire

// File: rtl/i2c_seg_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_seg_target_rx
// Brief    : Write-only I2C target; strobes received bytes to the display.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_seg_target_rx
    import i2c_seg_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [2:0] byte_idx,
    output logic       busy
);

    logic w_scl_level;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_level;
    logic w_sda_rise;
    logic w_sda_fall;
    logic w_scl_stable_high;
    logic w_start;
    logic w_stop;
    logic w_addr_ok;

    state_t r_state;
    state_t w_next_state;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_byte_full;
    logic [7:0] r_data_out;
    logic       r_data_valid;
    logic [2:0] r_byte_idx;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (scl_in),
        .level   (w_scl_level),
        .rise    (w_scl_rise),
        .fall    (w_scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (sda_in),
        .level   (w_sda_level),
        .rise    (w_sda_rise),
        .fall    (w_sda_fall)
    );

    // SCL high now and in the previous sample: an SDA edge here is START/STOP.
    assign w_scl_stable_high = w_scl_level & ~w_scl_rise;
    assign w_start           = w_sda_fall & w_scl_stable_high;
    assign w_stop            = w_sda_rise & w_scl_stable_high;
    assign w_addr_ok         = (r_shift[7:1] == I2C_ADDR) && !r_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = ADDR;
        end else if (w_stop) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_next_state = IDLE;
                ADDR: begin
                    if (w_scl_fall && r_byte_full) begin
                        w_next_state = w_addr_ok ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (w_scl_fall) w_next_state = DATA;
                DATA:     if (w_scl_fall && r_byte_full) w_next_state = DATA_ACK;
                DATA_ACK: if (w_scl_fall) w_next_state = DATA;
                IGNORE:   w_next_state = IGNORE;
                default:  w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_oe = 1'b0;
        busy   = 1'b0;
        case (r_state)
            ADDR_ACK: begin
                sda_oe = 1'b1;
                busy   = 1'b1;
            end
            DATA:     busy = 1'b1;
            DATA_ACK: begin
                sda_oe = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                sda_oe = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter, byte index and the display strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_byte_full  <= 1'b0;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_byte_idx   <= 3'd0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_start) begin
                r_bit_cnt   <= 3'd0;
                r_byte_full <= 1'b0;
                r_byte_idx  <= 3'd0;
            end else if (w_stop) begin
                r_bit_cnt   <= 3'd0;
                r_byte_full <= 1'b0;
            end else if (w_scl_rise) begin
                if ((r_state == ADDR || r_state == DATA) && !r_byte_full) begin
                    r_shift   <= {r_shift[6:0], w_sda_level};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_byte_full <= 1'b1;
                    end
                end
            end else if (w_scl_fall) begin
                case (r_state)
                    ADDR: begin
                        if (r_byte_full) begin
                            r_byte_full <= 1'b0;
                            r_bit_cnt   <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (r_byte_full) begin
                            r_byte_full  <= 1'b0;
                            r_bit_cnt    <= 3'd0;
                            r_data_out   <= r_shift;
                            r_data_valid <= 1'b1;
                        end
                    end
                    DATA_ACK: begin
                        if (r_byte_idx != BYTE_IDX_MAX) begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                        end
                    end
                    default: begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign byte_idx   = r_byte_idx;

endmodule
`default_nettype wire

// File: tb/tb_i2c_seg_target_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_seg_target_rx
// Brief    : Self-checking bench driving I2C master transactions into the target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_seg_target_rx;

    localparam int C_Q       = 50;
    localparam int C_K_START = 0;
    localparam int C_K_STOP  = 1;
    localparam int C_K_BYTE  = 2;

    typedef struct {
        int         kind;
        logic [7:0] b;
        logic       ack;
        logic       strobe;
        logic [2:0] idx;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       w_sda_line;
    logic       sda_oe;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] byte_idx;
    logic       busy;

    int         n_checks;
    int         n_errors;
    logic [7:0] q_data[$];
    logic [2:0] q_idx[$];
    logic       r_prev_valid;
    vec_t       vecs[$];

    assign w_sda_line = m_sda & ~sda_oe;

    i2c_seg_target_rx #(
        .I2C_ADDR (7'h2A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (m_scl),
        .sda_in     (w_sda_line),
        .sda_oe     (sda_oe),
        .data_out   (data_out),
        .data_valid (data_valid),
        .byte_idx   (byte_idx),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Strobe capture and single-cycle width check.
    always @(negedge clk) begin
        if (!rst && data_valid) begin
            q_data.push_back(data_out);
            q_idx.push_back(byte_idx);
            n_checks++;
            if (r_prev_valid) begin
                n_errors++;
                $display("FAIL valid_width: got 2+ cycles required 1");
            end
        end
        r_prev_valid = data_valid;
    end

    task automatic send_bit(input logic b, output logic oe_mid);
        m_sda = b;
        #C_Q;
        m_scl = 1'b1;
        #C_Q;
        oe_mid = sda_oe;
        #C_Q;
        m_scl = 1'b0;
        #C_Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], d);
        end
        send_bit(1'b1, ack);
    endtask

    task automatic do_start();
        m_sda = 1'b1;
        #C_Q;
        m_scl = 1'b1;
        #C_Q;
        m_sda = 1'b0;
        #C_Q;
        m_scl = 1'b0;
        #C_Q;
    endtask

    task automatic do_stop();
        m_sda = 1'b0;
        #C_Q;
        m_scl = 1'b1;
        #C_Q;
        m_sda = 1'b1;
        #C_Q;
    endtask

    task automatic add(input int k, input logic [7:0] b, input logic ack,
                       input logic stb, input logic [2:0] idx, input logic bsy);
        vec_t v;
        v.kind   = k;
        v.b      = b;
        v.ack    = ack;
        v.strobe = stb;
        v.idx    = idx;
        v.busy   = bsy;
        vecs.push_back(v);
    endtask

    task automatic check_one_strobe(input string tag, input logic [7:0] exp_d, input logic [2:0] exp_i);
        check({tag, "_strobe_cnt"}, q_data.size(), 1);
        if (q_data.size() > 0) begin
            check({tag, "_data"}, q_data.pop_front(), exp_d);
            check({tag, "_idx"}, q_idx.pop_front(), exp_i);
        end
        q_data.delete();
        q_idx.delete();
    endtask

    initial begin
        logic ack;
        logic d;
        string tag;
        logic [7:0] ten[10];

        n_checks     = 0;
        n_errors     = 0;
        r_prev_valid = 1'b0;
        m_scl        = 1'b1;
        m_sda        = 1'b1;
        rst          = 1'b1;
        ten = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

        // Good write: address + two data bytes.
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h54, 1'b1, 1'b0, 3'd0, 1'b1);
        add(C_K_BYTE,  8'h3F, 1'b1, 1'b1, 3'd0, 1'b1);
        add(C_K_BYTE,  8'h06, 1'b1, 1'b1, 3'd1, 1'b1);
        add(C_K_STOP,  8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // Wrong address.
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h56, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h12, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_STOP,  8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // Read request to our address.
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h55, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'hA5, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_STOP,  8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // Ten-byte write, index saturates at 7.
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h54, 1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            add(C_K_BYTE, ten[i], 1'b1, 1'b1, (i > 7) ? 3'd7 : 3'(i), 1'b1);
        end
        add(C_K_STOP,  8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        // Repeated START restarts the byte index.
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h54, 1'b1, 1'b0, 3'd0, 1'b1);
        add(C_K_BYTE,  8'h11, 1'b1, 1'b1, 3'd0, 1'b1);
        add(C_K_START, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        add(C_K_BYTE,  8'h54, 1'b1, 1'b0, 3'd0, 1'b1);
        add(C_K_BYTE,  8'h22, 1'b1, 1'b1, 3'd0, 1'b1);
        add(C_K_STOP,  8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

        repeat (4) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_idx", byte_idx, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        foreach (vecs[n]) begin
            tag = $sformatf("vec%0d", n);
            if (vecs[n].kind == C_K_BYTE) begin
                send_byte(vecs[n].b, ack);
                check({tag, "_ack"}, ack, vecs[n].ack);
                check({tag, "_strobe_cnt"}, q_data.size(), vecs[n].strobe);
                if (vecs[n].strobe && q_data.size() > 0) begin
                    check({tag, "_data"}, q_data[0], vecs[n].b);
                    check({tag, "_idx"}, q_idx[0], vecs[n].idx);
                end
                check({tag, "_released"}, sda_oe, 0);
            end else begin
                if (vecs[n].kind == C_K_START) do_start();
                else do_stop();
                check({tag, "_strobe_cnt"}, q_data.size(), 0);
            end
            check({tag, "_busy"}, busy, vecs[n].busy);
            q_data.delete();
            q_idx.delete();
        end

        // STOP in the middle of a data byte, then a fresh write.
        do_start();
        send_byte(8'h54, ack);
        send_bit(1'b1, d);
        send_bit(1'b0, d);
        send_bit(1'b1, d);
        send_bit(1'b0, d);
        do_stop();
        check("partial_strobe_cnt", q_data.size(), 0);
        check("partial_busy", busy, 0);
        q_data.delete();
        q_idx.delete();
        do_start();
        send_byte(8'h54, ack);
        send_byte(8'h5B, ack);
        check("after_partial_ack", ack, 1);
        check_one_strobe("after_partial", 8'h5B, 3'd0);
        do_stop();

        // Asynchronous reset while the data byte is being acknowledged.
        do_start();
        send_byte(8'h54, ack);
        for (int i = 7; i >= 0; i--) begin
            send_bit(ten[0][i], d);
        end
        check("pre_rst_sda_oe", sda_oe, 1);
        check("pre_rst_data", data_out, 8'h3F);
        q_data.delete();
        q_idx.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_idx", byte_idx, 0);
        check("mid_rst_valid", data_valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        do_stop();
        do_start();
        send_byte(8'h54, ack);
        check("post_rst_addr_ack", ack, 1);
        send_byte(8'h7F, ack);
        check("post_rst_data_ack", ack, 1);
        check_one_strobe("post_rst", 8'h7F, 3'd0);
        do_stop();
        check("post_rst_busy", busy, 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
